qspi_arbiter: RTL and testbench

QSPI_ARBITER -- requirements
Module: qspi_arbiter

---
 rtl/qspi_pkg.sv | 19 +
 rtl/qspi_arbiter.sv | 149 ++++++++++++++
 tb/tb_qspi_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_pkg.sv
// qspi_pkg: shared definitions for the QSPI flash arbiter.
//   - default address / data widths
//   - default starvation limit for pending game fetches
//   - arbiter FSM state encoding
package qspi_pkg;

    localparam int QSPI_ADDR_W       = 24;
    localparam int QSPI_DATA_W       = 32;
    localparam int QSPI_STARVE_LIMIT = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ_VID   = 3'd1,
        ST_WAIT_VID  = 3'd2,
        ST_REQ_GAME  = 3'd3,
        ST_WAIT_GAME = 3'd4
    } state_e;

endpackage

// File: rtl/qspi_arbiter.sv
// qspi_arbiter: shares one QSPI read engine between the video glyph fetcher
// and the game CPU word fetch. Video normally wins; a game fetch that has
// lost STARVE_LIMIT video transactions is promoted and pre-empts video
// during blanking. Only one memory transaction is ever outstanding.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   vid_req/vid_addr               video request (level) and address
//   vid_grant/vid_valid/vid_data   video accept pulse, read-data pulse, data
//   fetch/fetch_addr               game fetch pulse and address
//   fetch_result/fetch_busy        last game word, game pending/in flight
//   blank                          display blanking (allows promotion)
//   mem_req/mem_addr/mem_ready     request handshake to the QSPI engine
//   mem_valid/mem_data             read-data pulse from the QSPI engine
//
// state     | meaning
// ----------+---------------------------------------------------
// IDLE      | no transaction; choose the next requester
// REQ_VID   | video request presented, waiting for mem_ready
// WAIT_VID  | video request accepted, waiting for mem_valid
// REQ_GAME  | game request presented, waiting for mem_ready
// WAIT_GAME | game request accepted, waiting for mem_valid
module qspi_arbiter
    import qspi_pkg::*;
#(
    parameter int ADDR_W       = QSPI_ADDR_W,
    parameter int DATA_W       = QSPI_DATA_W,
    parameter int STARVE_LIMIT = QSPI_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_grant,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_data,
    input  logic              fetch,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_result,
    output logic              fetch_busy,
    input  logic              blank,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data
);

    localparam int               AGE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0]   game_addr_q, game_addr_d;
    logic [DATA_W-1:0]   fetch_result_q, fetch_result_d;
    logic                fetch_busy_q, fetch_busy_d;
    logic                game_pending_q, game_pending_d;
    logic [AGE_W-1:0]    age_q, age_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            mem_addr_q     <= '0;
            game_addr_q    <= '0;
            fetch_result_q <= '0;
            fetch_busy_q   <= 1'b0;
            game_pending_q <= 1'b0;
            age_q          <= '0;
        end else begin
            state_q        <= state_d;
            mem_addr_q     <= mem_addr_d;
            game_addr_q    <= game_addr_d;
            fetch_result_q <= fetch_result_d;
            fetch_busy_q   <= fetch_busy_d;
            game_pending_q <= game_pending_d;
            age_q          <= age_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        mem_addr_d     = mem_addr_q;
        game_addr_d    = game_addr_q;
        fetch_result_d = fetch_result_q;
        fetch_busy_d   = fetch_busy_q;
        game_pending_d = game_pending_q;
        age_d          = age_q;

        // A new game fetch is only captured when none is outstanding.
        if (fetch && !fetch_busy_q) begin
            game_addr_d    = fetch_addr;
            game_pending_d = 1'b1;
            fetch_busy_d   = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (game_pending_q && (age_q == AGE_MAX) && blank) begin
                    state_d    = ST_REQ_GAME;
                    mem_addr_d = game_addr_q;
                end else if (vid_req) begin
                    state_d    = ST_REQ_VID;
                    mem_addr_d = vid_addr;
                end else if (game_pending_q) begin
                    state_d    = ST_REQ_GAME;
                    mem_addr_d = game_addr_q;
                end
            end
            ST_REQ_VID: begin
                if (mem_ready) begin
                    state_d = ST_WAIT_VID;
                    if (game_pending_q && (age_q != AGE_MAX)) begin
                        age_d = age_q + 1'b1;
                    end
                end
            end
            ST_WAIT_VID: begin
                if (mem_valid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ_GAME: begin
                if (mem_ready) begin
                    state_d        = ST_WAIT_GAME;
                    game_pending_d = 1'b0;
                    age_d          = '0;
                end
            end
            ST_WAIT_GAME: begin
                if (mem_valid) begin
                    state_d        = ST_IDLE;
                    fetch_result_d = mem_data;
                    fetch_busy_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_req      = (state_q == ST_REQ_VID) || (state_q == ST_REQ_GAME);
    assign mem_addr     = mem_addr_q;
    assign vid_grant    = (state_q == ST_REQ_VID) && mem_ready;
    // Read data is forwarded straight through; no extra cycle of latency.
    assign vid_valid    = (state_q == ST_WAIT_VID) && mem_valid;
    assign vid_data     = mem_data;
    assign fetch_result = fetch_result_q;
    assign fetch_busy   = fetch_busy_q;

endmodule

// File: tb/tb_qspi_arbiter.sv
// tb_qspi_arbiter: self-checking bench for qspi_arbiter. The bench plays
// the QSPI engine; read data is a fixed function of the address.
module tb_qspi_arbiter;

    localparam int AW = 24;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_grant;
    logic          vid_valid;
    logic [DW-1:0] vid_data;
    logic          fetch = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic [DW-1:0] fetch_result;
    logic          fetch_busy;
    logic          blank = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ready = 1'b0;
    logic          mem_valid = 1'b0;
    logic [DW-1:0] mem_data = '0;

    typedef struct {
        logic          vid;
        logic [AW-1:0] addr;
    } sb_t;

    sb_t exp_q[$];
    sb_t fl_q[$];
    int  checks = 0;
    int  errors = 0;
    logic busy_prev = 1'b0;

    qspi_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vid_req      (vid_req),
        .vid_addr     (vid_addr),
        .vid_grant    (vid_grant),
        .vid_valid    (vid_valid),
        .vid_data     (vid_data),
        .fetch        (fetch),
        .fetch_addr   (fetch_addr),
        .fetch_result (fetch_result),
        .fetch_busy   (fetch_busy),
        .blank        (blank),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_valid    (mem_valid),
        .mem_data     (mem_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        if (a == 24'h001234) return 32'hDEADBEEF;
        return {8'hC3, a ^ 24'h5A5A5A};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Engine model: wait for mem_req, stall for 'stall' cycles, accept,
    // then return data 'lat' cycles after the accept cycle.
    task automatic engine(input int stall, input int lat, input bit drop_vid);
        int            n;
        logic [AW-1:0] hold;
        n = 0;
        while (!mem_req && n < 50) begin
            tick();
            n++;
        end
        chk("mem_req_seen", mem_req, 1);
        hold = mem_addr;
        for (int i = 0; i < stall; i++) begin
            mem_ready = 1'b0;
            tick();
            chk("stall_req_held", mem_req, 1);
            chk("stall_addr_held", mem_addr, hold);
            chk("stall_no_grant", vid_grant, 0);
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        if (drop_vid) vid_req = 1'b0;
        for (int i = 1; i < lat; i++) tick();
        mem_valid = 1'b1;
        mem_data  = mem_model(hold);
        tick();
        mem_valid = 1'b0;
    endtask

    // Scoreboard monitor: handshakes pop expected requests, completions pop
    // in-flight requests and check returned data.
    always @(negedge clk) begin
        sb_t e;
        if (!rst_n) begin
            exp_q.delete();
            fl_q.delete();
            busy_prev <= 1'b0;
        end else begin
            if (mem_req && mem_ready) begin
                if (exp_q.size() == 0) begin
                    chk("hs_unexpected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("hs_kind_grant", vid_grant, e.vid);
                    chk("hs_addr", mem_addr, e.addr);
                    fl_q.push_back(e);
                end
            end
            if (vid_valid) begin
                if (fl_q.size() == 0) begin
                    chk("vid_valid_unexpected", fl_q.size(), 1);
                end else begin
                    e = fl_q.pop_front();
                    chk("vid_valid_kind", e.vid, 1);
                    chk("vid_data", vid_data, mem_model(e.addr));
                end
            end
            if (busy_prev && !fetch_busy) begin
                if (fl_q.size() == 0) begin
                    chk("game_done_unexpected", fl_q.size(), 1);
                end else begin
                    e = fl_q.pop_front();
                    chk("game_done_kind", e.vid, 0);
                    chk("fetch_result", fetch_result, mem_model(e.addr));
                end
            end
            busy_prev <= fetch_busy;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] saved;

        // Reset values
        mem_valid = 1'b1;
        #12;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_vid_grant", vid_grant, 0);
        chk("rst_vid_valid", vid_valid, 0);
        chk("rst_fetch_result", fetch_result, 0);
        chk("rst_fetch_busy", fetch_busy, 0);
        chk("rst_age", dut.age_q, 0);
        mem_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Game-only path, 1-cycle arbitration after the pending flag
        fetch = 1'b1;
        fetch_addr = 24'h001234;
        exp_q.push_back('{vid: 1'b0, addr: 24'h001234});
        tick();
        fetch = 1'b0;
        chk("g_busy_rise", fetch_busy, 1);
        chk("g_req_t1", mem_req, 0);
        tick();
        chk("g_req_t2", mem_req, 1);
        chk("g_addr_t2", mem_addr, 24'h001234);
        engine(0, 3, 0);
        chk("g_result", fetch_result, 32'hDEADBEEF);
        chk("g_busy_fall", fetch_busy, 0);
        tick();

        // Simultaneous video and game: video first
        vid_req = 1'b1;
        vid_addr = 24'h00ABCD;
        fetch = 1'b1;
        fetch_addr = 24'h000777;
        exp_q.push_back('{vid: 1'b1, addr: 24'h00ABCD});
        exp_q.push_back('{vid: 1'b0, addr: 24'h000777});
        tick();
        fetch = 1'b0;
        chk("sim_vid_first_addr", mem_addr, 24'h00ABCD);
        engine(0, 2, 1);
        chk("sim_age_after_vid", dut.age_q, 1);
        engine(0, 2, 0);
        chk("sim_game_result", fetch_result, mem_model(24'h000777));
        chk("sim_age_cleared", dut.age_q, 0);
        tick();

        // Starvation with blank=0, then promotion when blank rises
        vid_req = 1'b1;
        vid_addr = 24'h002000;
        fetch = 1'b1;
        fetch_addr = 24'h000F00;
        tick();
        fetch = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{vid: 1'b1, addr: 24'h002000});
            engine(0, 2, 0);
        end
        chk("starve_age_sat", dut.age_q, 4);
        chk("starve_still_busy", fetch_busy, 1);
        blank = 1'b1;
        exp_q.push_back('{vid: 1'b0, addr: 24'h000F00});
        tick();
        chk("promote_addr", mem_addr, 24'h000F00);
        engine(0, 2, 0);
        chk("promote_result", fetch_result, mem_model(24'h000F00));
        chk("promote_age_clear", dut.age_q, 0);
        blank = 1'b0;
        exp_q.push_back('{vid: 1'b1, addr: 24'h002000});
        engine(0, 1, 1);
        tick();

        // Fetch while busy is ignored; stray mem_valid in IDLE ignored
        fetch = 1'b1;
        fetch_addr = 24'h000111;
        exp_q.push_back('{vid: 1'b0, addr: 24'h000111});
        tick();
        fetch_addr = 24'h000999;
        tick();
        fetch = 1'b0;
        engine(0, 2, 0);
        chk("ign_result", fetch_result, mem_model(24'h000111));
        tick();
        saved = fetch_result;
        mem_valid = 1'b1;
        mem_data = 32'h12345678;
        #1;
        chk("stray_vid_valid", vid_valid, 0);
        tick();
        mem_valid = 1'b0;
        chk("stray_result_held", fetch_result, saved);
        chk("stray_busy", fetch_busy, 0);
        chk("stray_req", mem_req, 0);

        // Backpressure in REQ_VID
        vid_req = 1'b1;
        vid_addr = 24'h00BEEF;
        exp_q.push_back('{vid: 1'b1, addr: 24'h00BEEF});
        tick();
        engine(5, 2, 1);
        tick();

        // Reset during WAIT_GAME
        fetch = 1'b1;
        fetch_addr = 24'h000333;
        exp_q.push_back('{vid: 1'b0, addr: 24'h000333});
        tick();
        fetch = 1'b0;
        tick();
        chk("rst_mid_req", mem_req, 1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("rst_mid_in_wait", mem_req, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstm_mem_req", mem_req, 0);
        chk("rstm_mem_addr", mem_addr, 0);
        chk("rstm_fetch_busy", fetch_busy, 0);
        chk("rstm_fetch_result", fetch_result, 0);
        chk("rstm_vid_grant", vid_grant, 0);
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        mem_valid = 1'b1;
        mem_data = 32'hFFFF0000;
        #1;
        chk("late_vid_valid", vid_valid, 0);
        tick();
        mem_valid = 1'b0;
        chk("late_fetch_result", fetch_result, 0);
        chk("late_fetch_busy", fetch_busy, 0);
        chk("late_mem_req", mem_req, 0);
        tick();

        chk("sb_exp_empty", exp_q.size(), 0);
        chk("sb_flight_empty", fl_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
